// File: rtl/disp_scan6_if.sv
// disp_scan6_if: digit inputs, blink controls and display outputs of the
// six-digit multiplexed 7-segment driver.
interface disp_scan6_if;
  logic [1:0] HH;
  logic [3:0] HL;
  logic [2:0] MH;
  logic [3:0] ML;
  logic [2:0] SH;
  logic [3:0] SL;
  logic [1:0] SETMODE;
  logic       EN2HZ;
  logic [5:0] DIGIT_SEL;
  logic [6:0] SEG;
  logic       DP;

  modport master (
    output HH, HL, MH, ML, SH, SL, SETMODE, EN2HZ,
    input  DIGIT_SEL, SEG, DP
  );

  modport slave (
    input  HH, HL, MH, ML, SH, SL, SETMODE, EN2HZ,
    output DIGIT_SEL, SEG, DP
  );
endinterface

// File: rtl/disp_scan6.sv
// disp_scan6: time-multiplexes HH:MM:SS onto one active-low segment bus.
// Each frame is drawn from a snapshot latched when the scan wraps to digit 0,
// with hour-tens zero blanking, range dashes and blinking of the set field.
module disp_scan6 #(
  parameter int SCAN_DIV = 16384
) (
  input  logic        CLK,
  input  logic        RST,
  disp_scan6_if.slave bus
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          first_q, first_d;
  logic          blink_q, blink_d;
  logic [1:0]    mode_prev_q, mode_prev_d;
  logic [1:0]    hh_q, hh_d;
  logic [3:0]    hl_q, hl_d, ml_q, ml_d, sl_q, sl_d;
  logic [2:0]    mh_q, mh_d, sh_q, sh_d;
  logic [5:0]    sel_q, sel_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          tc, load, mode_changed, field_hit, blank;
  logic [3:0]    dig_val;
  logic          dig_bad, dig_lz;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = SEG_DASH;
    endcase
  endfunction

  // Scan timing, snapshot loading, blink phase and registered output decode
  always_comb begin
    tc      = (cnt_q == CNT_MAX);
    cnt_d   = tc ? '0 : cnt_q + CW'(1);
    first_d = first_q;
    idx_d   = idx_q;
    load    = 1'b0;
    hh_d = hh_q; hl_d = hl_q; mh_d = mh_q;
    ml_d = ml_q; sh_d = sh_q; sl_d = sl_q;

    // The first TC shows digit 0 instead of advancing, so the first frame
    // after reset starts at the leftmost digit.
    if (tc) begin
      if (first_q) begin
        first_d = 1'b0;
        idx_d   = 3'd0;
        load    = 1'b1;
      end else if (idx_q == 3'd5) begin
        idx_d = 3'd0;
        load  = 1'b1;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end

    if (load) begin
      hh_d = bus.HH; hl_d = bus.HL; mh_d = bus.MH;
      ml_d = bus.ML; sh_d = bus.SH; sl_d = bus.SL;
    end

    mode_changed = (bus.SETMODE != mode_prev_q);
    mode_prev_d  = bus.SETMODE;
    blink_d      = mode_changed ? 1'b0 : (bus.EN2HZ ? ~blink_q : blink_q);

    dig_val = 4'd0;
    dig_bad = 1'b0;
    dig_lz  = 1'b0;
    case (idx_d)
      3'd0: begin dig_val = {2'b00, hh_d}; dig_bad = (hh_d == 2'd3); dig_lz = (hh_d == 2'd0); end
      3'd1: begin dig_val = hl_d;          dig_bad = (hl_d > 4'd9); end
      3'd2: begin dig_val = {1'b0, mh_d};  dig_bad = (mh_d > 3'd5); end
      3'd3: begin dig_val = ml_d;          dig_bad = (ml_d > 4'd9); end
      3'd4: begin dig_val = {1'b0, sh_d};  dig_bad = (sh_d > 3'd5); end
      3'd5: begin dig_val = sl_d;          dig_bad = (sl_d > 4'd9); end
      default: begin dig_val = 4'd0; dig_bad = 1'b0; dig_lz = 1'b0; end
    endcase

    // A cycle with a SETMODE change already counts as phase 0, so a stale
    // phase never blanks the newly selected field.
    field_hit = (bus.SETMODE != 2'd0) && (bus.SETMODE == idx_d[2:1] + 2'd1);
    blank     = blink_q && !mode_changed && field_hit;

    sel_d = 6'b111111;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (!(first_q && !tc)) begin
      sel_d = ~(6'b000001 << idx_d);
      dp_d  = !((idx_d == 3'd1) || (idx_d == 3'd3));
      if (blank || dig_lz)
        seg_d = SEG_OFF;
      else if (dig_bad)
        seg_d = SEG_DASH;
      else
        seg_d = seg_decode(dig_val);
    end
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      first_q     <= 1'b1;
      blink_q     <= 1'b0;
      mode_prev_q <= 2'd0;
      hh_q <= '0; hl_q <= '0; mh_q <= '0;
      ml_q <= '0; sh_q <= '0; sl_q <= '0;
      sel_q       <= 6'b111111;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      first_q     <= first_d;
      blink_q     <= blink_d;
      mode_prev_q <= mode_prev_d;
      hh_q <= hh_d; hl_q <= hl_d; mh_q <= mh_d;
      ml_q <= ml_d; sh_q <= sh_d; sl_q <= sl_d;
      sel_q       <= sel_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign bus.DIGIT_SEL = sel_q;
  assign bus.SEG       = seg_q;
  assign bus.DP        = dp_q;

endmodule

// File: tb/tb_disp_scan6.sv
// tb_disp_scan6: random digit/blink stimulus against a frame-level model of
// the display (edge count -> digit index, frame snapshots, blink phase).
module tb_disp_scan6;

  localparam int D = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  disp_scan6_if bus ();

  disp_scan6 #(.SCAN_DIV(D)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int in_v [6];
  int snap [6];
  int lim  [6] = '{2, 9, 5, 9, 5, 9};
  int maxv [6] = '{3, 15, 7, 15, 7, 15};
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};
  int k;      // rising edges since reset release
  int p;      // blink phase
  int sp;     // SETMODE seen at the previous edge
  int mode;
  int en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, k);
    end
  endtask

  task automatic drive();
    bus.HH      = 2'(in_v[0]);
    bus.HL      = 4'(in_v[1]);
    bus.MH      = 3'(in_v[2]);
    bus.ML      = 4'(in_v[3]);
    bus.SH      = 3'(in_v[4]);
    bus.SL      = 4'(in_v[5]);
    bus.SETMODE = 2'(mode);
    bus.EN2HZ   = (en != 0);
  endtask

  task automatic model_reset();
    k  = 0;
    p  = 0;
    sp = 0;
    foreach (snap[i]) snap[i] = 0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_sel"}, 32'(bus.DIGIT_SEL), 32'h3F);
    check({tag, "_seg"}, 32'(bus.SEG), 32'h7F);
    check({tag, "_dp"},  32'(bus.DP), 32'h1);
  endtask

  task automatic step_check();
    int idx;
    logic [5:0] es;
    logic [6:0] eg;
    logic ed;
    logic blank;
    @(posedge clk);
    k++;
    if ((k % D == 0) && (((k / D) - 1) % 6 == 0)) snap = in_v;
    es = 6'h3F; eg = 7'h7F; ed = 1'b1;
    if (k >= D) begin
      idx   = ((k / D) - 1) % 6;
      es    = ~(6'b000001 << idx);
      ed    = !(idx == 1 || idx == 3);
      blank = (p != 0) && (mode == sp) && (mode != 0) && (mode == idx / 2 + 1);
      if (blank || (idx == 0 && snap[0] == 0)) eg = 7'h7F;
      else if (snap[idx] > lim[idx])            eg = 7'b0111111;
      else                                      eg = seg_tab[snap[idx]];
    end
    if (mode != sp) p = 0;
    else if (en != 0) p = 1 - p;
    sp = mode;
    #1;
    check("sel", 32'(bus.DIGIT_SEL), 32'(es));
    check("seg", 32'(bus.SEG), 32'(eg));
    check("dp",  32'(bus.DP), 32'(ed));
  endtask

  task automatic run(input int n);
    int j;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        j = $urandom_range(0, 5);
        in_v[j] = $urandom_range(0, maxv[j]);
      end
      en = ($urandom_range(0, 7) == 0) ? 1 : 0;
      if ($urandom_range(0, 29) == 0) mode = $urandom_range(0, 3);
      drive();
      step_check();
    end
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1 check_idle("rst_async");
    @(posedge clk);
    #1 check_idle("rst_hold");
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    in_v     = '{1, 2, 3, 4, 5, 6};
    mode     = 0;
    en       = 0;
    model_reset();
    drive();
    repeat (2) @(posedge clk);
    #1 check_idle("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    run(2000);
    mid_reset();
    run(2000);
    mid_reset();
    run(2000);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/disp_scan6.md
# disp_scan6

Six-digit multiplexed 7-segment display driver for the clock datapath. It sits directly downstream of the hour counter (cnt24) and the minute/second counters, and consumes their BCD digit outputs. It time-multiplexes the six digits HH:MM:SS onto one shared segment bus, with leading-zero blanking on the hour tens digit, blinking of the field currently being set, and tear-free frame snapshots.

## Interface
- SCAN_DIV, default 16384: CLK cycles each digit stays selected; legal range 2..2^20.
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- HH  input  2  hour tens (0..2), from cnt24 QH.
- HL  input  4  hour units (0..9).
- MH  input  3  minute tens (0..5).
- ML  input  4  minute units (0..9).
- SH  input  3  second tens (0..5).
- SL  input  4  second units (0..9).
- SETMODE  input  2  field to blink: 00 none, 01 hours, 10 minutes, 11 seconds.
- EN2HZ  input  1  one-CLK-wide pulse at 2 Hz that toggles the blink phase.
- DIGIT_SEL  output  6  active-low one-hot digit enable; bit0 = HH (leftmost), bit5 = SL.
- SEG  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- DP  output  1  active-low decimal point, used as the colon separator.

## Operation
- Scan counter runs 0..SCAN_DIV-1 and wraps. Terminal count (TC) = counter at SCAN_DIV-1.
- Digit index runs 0..5 and advances by one on each TC; it wraps 5→0.
- Snapshot register holds all six input digits. It loads on TC when the index is 5, or on the first TC after reset. A frame is therefore always displayed from one consistent snapshot; input changes mid-frame are not shown until the next frame.
- Decode, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Out-of-range digits display a dash, SEG=0111111:
  - HL, ML, SL > 9
  - HH = 3
  - MH, SH > 5
- Leading-zero blanking: when snapshot HH = 0, SEG=1111111 on digit 0.
- DP=0 on digit indices 1 and 3; DP=1 on all other digits.
- Blink phase is a 1-bit register:
  - Toggles on EN2HZ.
  - Forced to 0 in any cycle where SETMODE differs from its value in the previous cycle; this takes priority over EN2HZ.
- When blink phase = 1 and the current digit belongs to the SETMODE field (01: indices 0,1; 10: indices 2,3; 11: indices 4,5):
  - SEG=1111111
  - DP stays as specified above.
  - DIGIT_SEL stays active.
- SETMODE=00 never blanks.

## Timing
- Reset values:
  - DIGIT_SEL=111111, SEG=1111111, DP=1
  - scan counter 0, digit index 0, blink phase 0, snapshot all 0
  - "first TC" flag set
- All outputs are registered. DIGIT_SEL, SEG and DP change together one CLK after the TC edge that selects the new index.
- First display after reset release:
  - Outputs go active on the clock edge after the first TC, i.e. SCAN_DIV clock edges after reset deasserts.
  - That first display shows index 0 from a snapshot taken at that same TC.
- Blink decisions use the blink phase value at the CLK edge where the outputs are registered.
- Exactly one DIGIT_SEL bit is low at any time after the first TC. No cycle ever has two bits low.
- When reset asserts mid-frame, all outputs return to their reset values immediately (asynchronously). Scanning restarts from index 0 after release.

## Test plan
- Reset and first scan: SCAN_DIV=4, inputs 1,2,3,4,5,6, release RST → outputs idle for the first 3 edges; 4th edge gives DIGIT_SEL=111110, SEG=1111001; indices then advance every 4 CLKs; DP=0 only on indices 1 and 3.
- Full decode: step HL through 0..15 one frame at a time → index 1 shows the listed patterns for 0..9 and 0111111 for 10..15. Set HH=0 → index 0 shows 1111111. Set HH=3 → index 0 shows 0111111.
- Snapshot: change ML from 3 to 7 while index 1 is displayed → index 3 still shows 3 in that frame and shows 7 in the next frame.
- Blink: SETMODE=10, pulse EN2HZ once → indices 2 and 3 show SEG=1111111 while DIGIT_SEL stays active and other digits are unaffected. Pulse again → all digits visible. Change SETMODE to 11 while phase=1 → phase is cleared and nothing is blanked.
- Simultaneous events: an EN2HZ pulse in the same cycle as a SETMODE change → phase is 0 afterwards.
- Reset mid-operation: assert RST at index 4 → next sample shows DIGIT_SEL=111111, SEG=1111111, DP=1; after release, scanning restarts at index 0.
